// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: iterative RV32M multiply/divide sequencer for the EX stage.
// Decodes M-extension R-type instructions from the raw instruction word. It then
// runs a shift-add multiplier or a restoring divider for XLEN cycles. While the
// work is in progress it holds the pipeline with stall. When the work ends it
// presents the result for exactly one cycle, qualified by done.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   valid     EX stage holds a live instruction
//   I_in      instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25])
//   rs1_data  operand A (multiplicand / dividend)
//   rs2_data  operand B (multiplier / divisor)
//   stall     freeze PC/IF/ID/EX
//   done      result valid this cycle
//   result    MUL/DIV result, holds its last value outside done
//   busy      sequencer not idle
//
// Optional feature macro: MULDIV_EARLY_OUT_EN. When this macro is defined, the
// following operations finish after a single CALC cycle:
//   - divide by zero
//   - signed divide overflow
//   - multiply by zero

module muldiv_seq_ctrl #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid,
   input  logic [31:0]     I_in,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      f3_q, f3_d;
   logic            neg_quo_q, neg_quo_d;   // negate product / quotient
   logic            neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
   logic [XLEN-1:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
   logic [XLEN-1:0] hi_q, hi_d;             // product high half / partial remainder
   logic [XLEN-1:0] lo_q, lo_d;             // multiplier->product low / dividend->quotient
   logic [XLEN-1:0] result_q, result_d;
`ifdef MULDIV_EARLY_OUT_EN
   logic            early_q, early_d;
   logic            early_in;
`endif

   logic            m_op;
   logic [2:0]      f3_in;
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   mul_sum, div_shift, div_trial;
   logic            div_ok;
   logic [XLEN-1:0] mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0] quo_s, rem_s;
   logic            unused_i_bits;

   assign unused_i_bits = ^{I_in[24:15], I_in[11:7]};

   assign m_op  = valid && (I_in[6:0] == 7'b0110011) && (I_in[31:25] == 7'b0000001);
   assign f3_in = I_in[14:12];

   // rs1 is signed for MULH, MULHSU, DIV and REM. rs2 is signed for MULH, DIV and REM.
   assign a_signed = (f3_in == 3'b001) || (f3_in == 3'b010) || (f3_in == 3'b100) || (f3_in == 3'b110);
   assign b_signed = (f3_in == 3'b001) || (f3_in == 3'b100) || (f3_in == 3'b110);
   assign a_neg    = a_signed && rs1_data[XLEN-1];
   assign b_neg    = b_signed && rs2_data[XLEN-1];
   assign a_mag    = a_neg ? -rs1_data : rs1_data;
   assign b_mag    = b_neg ? -rs2_data : rs2_data;

`ifdef MULDIV_EARLY_OUT_EN
   assign early_in = f3_in[2]
                   ? ((rs2_data == '0) ||
                      (!f3_in[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1)))
                   : ((rs1_data == '0) || (rs2_data == '0));
`endif

   // Multiply step: {hi,lo} holds the partial product and the remaining multiplier bits.
   // Each step adds the multiplicand into the high half when lo[0] is set, then shifts right.
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_hi_nx = mul_sum[XLEN:1];
   assign mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};

   // Restoring divide step. A borrow out of the trial subtraction keeps the shifted remainder.
   // With a divisor of zero the quotient comes out all ones and the remainder equals |rs1|.
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_trial = div_shift - {1'b0, opnd_q};
   assign div_ok    = ~div_trial[XLEN];
   assign div_hi_nx = div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
   assign div_lo_nx = {lo_q[XLEN-2:0], div_ok};

   assign prod   = {mul_hi_nx, mul_lo_nx};
   assign prod_s = neg_quo_q ? -prod : prod;
   assign quo_s  = neg_quo_q ? -div_lo_nx : div_lo_nx;
   assign rem_s  = neg_rem_q ? -div_hi_nx : div_hi_nx;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      f3_d      = f3_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      opnd_d    = opnd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      result_d  = result_q;
`ifdef MULDIV_EARLY_OUT_EN
      early_d   = early_q;
`endif
      stall     = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (m_op) begin
               stall   = 1'b1;
               state_d = CALC;
               cnt_d   = '0;
               f3_d    = f3_in;
               hi_d    = '0;
               opnd_d  = f3_in[2] ? b_mag : a_mag;
               lo_d    = f3_in[2] ? a_mag : b_mag;
               // A divide by zero keeps an unsigned all-ones quotient and a remainder equal to rs1.
               neg_quo_d = (a_neg ^ b_neg) && !(f3_in[2] && (rs2_data == '0));
               neg_rem_d = a_neg;
`ifdef MULDIV_EARLY_OUT_EN
               early_d = early_in;
`endif
            end
         end

         CALC: begin
            stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_q) begin
               state_d = DONE;
               if (!f3_q[2])
                  result_d = '0;
               else if (opnd_q == '0)
                  result_d = f3_q[1] ? (neg_rem_q ? -lo_q : lo_q) : '1;
               else
                  result_d = f3_q[1] ? '0 : lo_q;    // overflow: |rs1| is the minimum value
            end else
`endif
            begin
               hi_d = f3_q[2] ? div_hi_nx : mul_hi_nx;
               lo_d = f3_q[2] ? div_lo_nx : mul_lo_nx;
               if (cnt_q == CW'(XLEN-1)) begin
                  state_d = DONE;
                  unique case (f3_q)
                     3'b000:                 result_d = prod_s[XLEN-1:0];
                     3'b001, 3'b010, 3'b011: result_d = prod_s[2*XLEN-1:XLEN];
                     3'b100, 3'b101:         result_d = quo_s;
                     default:                result_d = rem_s;
                  endcase
               end
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q != IDLE);
   assign result = result_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         f3_q      <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         result_q  <= '0;
`ifdef MULDIV_EARLY_OUT_EN
         early_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         f3_q      <= f3_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         opnd_q    <= opnd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         result_q  <= result_d;
`ifdef MULDIV_EARLY_OUT_EN
         early_q   <= early_d;
`endif
      end
   end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
Iterative RV32M multiply/divide sequencer beside the main ALU in the EX stage. Decodes M-extension R-type instructions from the raw instruction word and runs a shift-add multiplier or restoring divider over XLEN cycles. Holds the pipeline with `stall` until the result is ready, then presents it for exactly one cycle with `done`.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid  input  1  EX stage holds a live instruction
I_in  input  32  instruction word; opcode I_in[6:0], funct3 I_in[14:12], funct7 I_in[31:25]
rs1_data  input  XLEN  operand A (dividend / multiplicand)
rs2_data  input  XLEN  operand B (divisor / multiplier)
stall  output  1  freeze PC/IF/ID/EX
done  output  1  result valid this cycle
result  output  XLEN  MUL/DIV result
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- M-op decode: valid & I_in[6:0]==7'b0110011 & I_in[31:25]==7'b0000001.
- funct3 mapping: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, CALC, DONE (2-bit encoding).
- Reset: state=IDLE, counter=0, all internal registers 0, stall=0, done=0, busy=0, result=0. Asserting rst_n low mid-CALC aborts immediately; no partial result is ever emitted.
- IDLE:
  - On M-op: latch funct3, operand magnitudes and sign flags, clear accumulator, counter=0, go to CALC.
  - stall is asserted combinationally in this same cycle (stall = IDLE & M-op | CALC).
  - Non-M instructions: no state change, stall=0.
- Sign rules:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - U variants: both operands unsigned.
  - Magnitude = two's-complement negate when signed and MSB=1.
- CALC:
  - One iteration per cycle: multiply is 2*XLEN-bit shift-add; divide is restoring (shift remainder, trial subtract, set quotient bit).
  - counter increments each cycle; after the XLEN-th iteration (counter==XLEN-1) go to DONE.
- DONE:
  - Apply sign correction.
  - result register loaded on CALC->DONE transition: MUL = low XLEN bits of product; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Quotient negative iff operand signs differ; remainder takes dividend sign.
  - done=1, stall=0 for exactly one cycle, then IDLE unconditionally.
  - valid/I_in in the DONE cycle are ignored; the completing instruction is still in EX and must not restart.
- Latency: accept at cycle 0, done at cycle XLEN+1 (33 for XLEN=32), fixed, independent of operands.
- Special cases, with results per RISC-V spec:
  - Divide by zero: quotient = all ones; remainder = rs1_data.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
  - Detected at acceptance; same fixed latency.
- Operand changes on rs1_data/rs2_data during CALC have no effect (latched at accept).
- result holds its last value outside DONE; done is the only valid qualifier.

Optional Feature:
MULDIV_EARLY_OUT_EN:
- Defined: divide-by-zero, signed overflow, and multiply with either operand zero skip iteration. CALC lasts one cycle, so done is asserted at cycle 2. All other ops keep XLEN+1 latency.
- Undefined: every M-op takes exactly XLEN+1 cycles.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD -> stall asserted in cycles 0..32; done at cycle 33; result=0xFFFFFFEB.
2. MULH rs1=rs2=0x80000000 -> result=0x40000000; MULHU same operands -> 0x40000000; MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
3. DIVU 100/7 -> 14; REMU -> 2; DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
4. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Latency 33, or 2 with MULDIV_EARLY_OUT_EN.
5. valid held high with the same M-op through DONE -> exactly one done pulse; back-to-back ADD in next cycle -> stall=0, busy=0.
6. rst_n low at cycle 10 of a DIVU -> stall/busy/done/result=0 asynchronously; no done pulse afterwards; new MUL 3*4 after release -> result=12 at cycle 33.
